// File: rtl/m68k_bus_initiator_if.sv
// Command/response and 68000-style bus signals of the m68k_bus_initiator.
// master = the initiator itself; slave = command source plus bus responder.
interface m68k_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [2:0]  cmd_fc;
    logic [22:0] cmd_addr;
    logic [1:0]  cmd_be;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_autovec;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic [2:0]  fc;
    logic [22:0] addr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        dtack_n;
    logic        vpa_n;
    logic        berr_n;

    modport master (
        input  cmd_valid, cmd_we, cmd_fc, cmd_addr, cmd_be, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_autovec,
        output as_n, uds_n, lds_n, rw, fc, addr, dout,
        input  din, dtack_n, vpa_n, berr_n
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_fc, cmd_addr, cmd_be, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_autovec,
        input  as_n, uds_n, lds_n, rw, fc, addr, dout,
        output din, dtack_n, vpa_n, berr_n
    );
endinterface

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus cycle generator driven by a one-outstanding command port.
// Optional STROBE timeout: define M68K_BUS_INITIATOR_TIMEOUT_EN.
module m68k_bus_initiator #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    m68k_bus_initiator_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [1:0]  be_q, be_d;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic        rw_q, rw_d;
    logic [2:0]  fc_q, fc_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_autovec_q, rsp_autovec_d;
    logic        accept_s;
    logic        terms_idle_s;

`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT > 32'sd0) && (TO_WIDTH > 32'sd0);
`endif

    assign accept_s     = bus.cmd_valid & cmd_ready_q;
    assign terms_idle_s = bus.dtack_n & bus.vpa_n & bus.berr_n;

    // Next-state and next-output computation for the bus cycle sequencer.
    always_comb begin
        state_d       = state_q;
        be_d          = be_q;
        as_n_d        = as_n_q;
        uds_n_d       = uds_n_q;
        lds_n_d       = lds_n_q;
        rw_d          = rw_q;
        fc_d          = fc_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_autovec_d = rsp_autovec_q;
`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d        = bus.cmd_addr;
                    fc_d          = bus.cmd_fc;
                    be_d          = bus.cmd_be;
                    rsp_rdata_d   = 16'h0000;
                    rsp_autovec_d = 1'b0;
                    if (bus.cmd_be == 2'b00) begin
                        // Illegal byte enables: report at once, bus stays quiet.
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_SETUP;
                        rsp_err_d = 1'b0;
                        rw_d      = ~bus.cmd_we;
                        dout_d    = bus.cmd_we ? bus.cmd_wdata : 16'h0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                as_n_d  = 1'b0;
                uds_n_d = ~be_q[1];
                lds_n_d = ~be_q[0];
`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_STROBE: begin
                if (!bus.berr_n) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 16'h0000;
                end else if (!bus.dtack_n) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rw_q ? bus.din : 16'h0000;
                end else if (!bus.vpa_n) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_autovec_d = 1'b1;
                    rsp_rdata_d   = rw_q ? bus.din : 16'h0000;
                end else begin
`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 16'h0000;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                    end
`else
                    state_d = ST_STROBE;
`endif
                end
                // Any exit from STROBE releases the strobes on DONE entry.
                if (state_d == ST_DONE) begin
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                end else begin
                    as_n_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (terms_idle_s) begin
                    state_d = ST_IDLE;
                    rw_d    = 1'b1;
                    dout_d  = 16'h0000;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                as_n_d  = 1'b1;
                uds_n_d = 1'b1;
                lds_n_d = 1'b1;
                rw_d    = 1'b1;
                dout_d  = 16'h0000;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            be_q          <= 2'b00;
            as_n_q        <= 1'b1;
            uds_n_q       <= 1'b1;
            lds_n_q       <= 1'b1;
            rw_q          <= 1'b1;
            fc_q          <= 3'b000;
            addr_q        <= 23'h000000;
            dout_q        <= 16'h0000;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 16'h0000;
            rsp_err_q     <= 1'b0;
            rsp_autovec_q <= 1'b0;
`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            be_q          <= be_d;
            as_n_q        <= as_n_d;
            uds_n_q       <= uds_n_d;
            lds_n_q       <= lds_n_d;
            rw_q          <= rw_d;
            fc_q          <= fc_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_autovec_q <= rsp_autovec_d;
`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_autovec = rsp_autovec_q;
    assign bus.as_n        = as_n_q;
    assign bus.uds_n       = uds_n_q;
    assign bus.lds_n       = lds_n_q;
    assign bus.rw          = rw_q;
    assign bus.fc          = fc_q;
    assign bus.addr        = addr_q;
    assign bus.dout        = dout_q;
endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed self-checking bench for m68k_bus_initiator; the bench plays command source and responder.
module tb_m68k_bus_initiator;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;

    m68k_bus_initiator_if bif ();

    m68k_bus_initiator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results captured by run_cmd
    logic        got_rsp;
    int          lat;
    int          strobe_cnt;
    logic        as_seen;
    logic        cap_rw, cap_uds, cap_lds;
    logic [2:0]  cap_fc;
    logic [22:0] cap_addr;
    logic [15:0] cap_dout;
    logic [15:0] r_rdata;
    logic        r_err, r_autovec;
    logic [15:0] first_rdata;
    logic        ready_back;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // term: 0 none, 1 dtack, 2 vpa, 3 berr+dtack; asserted on the 2nd AS-low cycle
    task automatic run_cmd(input logic we, input logic [2:0] fc, input logic [22:0] addr,
                           input logic [1:0] be, input logic [15:0] wdata, input logic [15:0] rdata,
                           input int term, input int hold, input int budget);
        int cyc;
        int scnt;
        got_rsp = 1'b0; lat = 0; as_seen = 1'b0; ready_back = 1'b0;
        cap_rw = 1'b1; cap_uds = 1'b1; cap_lds = 1'b1;
        cap_fc = 3'b000; cap_addr = 23'h0; cap_dout = 16'h0;
        @(negedge clk);
        bif.cmd_valid = 1'b1; bif.cmd_we = we; bif.cmd_fc = fc; bif.cmd_addr = addr;
        bif.cmd_be = be; bif.cmd_wdata = wdata; bif.din = rdata;
        @(posedge clk);
        cyc = 0; scnt = 0;
        while (cyc < budget && !got_rsp) begin
            @(negedge clk);
            cyc++;
            bif.cmd_valid = 1'b0;
            if (cyc == 1) first_rdata = bif.rsp_rdata;
            if (!bif.as_n) begin
                scnt++;
                if (scnt == 1) begin
                    as_seen = 1'b1; cap_rw = bif.rw; cap_uds = bif.uds_n; cap_lds = bif.lds_n;
                    cap_fc = bif.fc; cap_addr = bif.addr; cap_dout = bif.dout;
                end
                if (scnt == 2) begin
                    if (term == 1) bif.dtack_n = 1'b0;
                    if (term == 2) bif.vpa_n = 1'b0;
                    if (term == 3) begin bif.berr_n = 1'b0; bif.dtack_n = 1'b0; end
                end
            end
            if (bif.rsp_valid) begin
                got_rsp = 1'b1; lat = cyc;
                r_rdata = bif.rsp_rdata; r_err = bif.rsp_err; r_autovec = bif.rsp_autovec;
            end
        end
        strobe_cnt = scnt;
        if (got_rsp) begin
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check_val("ready_while_term_held", 32'(bif.cmd_ready), 32'd0);
            end
            bif.dtack_n = 1'b1; bif.vpa_n = 1'b1; bif.berr_n = 1'b1;
            for (int i = 0; i < 10 && !ready_back; i++) begin
                @(negedge clk);
                if (bif.cmd_ready) ready_back = 1'b1;
            end
            check_val("ready_return", 32'(ready_back), 32'd1);
        end
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        reset = 1'b1;
        bif.cmd_valid = 1'b0; bif.cmd_we = 1'b0; bif.cmd_fc = 3'b000; bif.cmd_addr = 23'h0;
        bif.cmd_be = 2'b00; bif.cmd_wdata = 16'h0; bif.din = 16'h0;
        bif.dtack_n = 1'b1; bif.vpa_n = 1'b1; bif.berr_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_as_n", 32'(bif.as_n), 32'd1);
        check_val("rst_ds_n", 32'({bif.uds_n, bif.lds_n}), 32'd3);
        check_val("rst_rw", 32'(bif.rw), 32'd1);
        check_val("rst_fc", 32'(bif.fc), 32'd0);
        check_val("rst_addr", 32'(bif.addr), 32'd0);
        check_val("rst_dout", 32'(bif.dout), 32'd0);
        check_val("rst_rsp", 32'({bif.rsp_valid, bif.rsp_err, bif.rsp_autovec}), 32'd0);
        check_val("rst_rdata", 32'(bif.rsp_rdata), 32'd0);
        check_val("rst_ready", 32'(bif.cmd_ready), 32'd1);

        // Word write with a one-cycle-late DTACK responder
        run_cmd(1'b1, 3'b101, 23'h080000, 2'b11, 16'hBEEF, 16'h0000, 1, 0, 50);
        check_val("wr_got", 32'(got_rsp), 32'd1);
        check_val("wr_latency", 32'(lat), 32'd4);
        check_val("wr_rw", 32'(cap_rw), 32'd0);
        check_val("wr_ds", 32'({cap_uds, cap_lds}), 32'd0);
        check_val("wr_addr", 32'(cap_addr), 32'h080000);
        check_val("wr_fc", 32'(cap_fc), 32'd5);
        check_val("wr_dout", 32'(cap_dout), 32'hBEEF);
        check_val("wr_err", 32'({r_err, r_autovec}), 32'd0);
        check_val("wr_rdata", 32'(r_rdata), 32'd0);
        check_val("wr_rw_idle", 32'(bif.rw), 32'd1);
        check_val("wr_dout_idle", 32'(bif.dout), 32'd0);

        // Lower-byte read
        run_cmd(1'b0, 3'b001, 23'h000123, 2'b01, 16'hFFFF, 16'h1234, 1, 0, 50);
        check_val("rd_ds", 32'({cap_uds, cap_lds}), 32'd2);
        check_val("rd_rw", 32'(cap_rw), 32'd1);
        check_val("rd_dout", 32'(cap_dout), 32'd0);
        check_val("rd_rdata", 32'(r_rdata), 32'h1234);
        check_val("rd_flags", 32'({r_err, r_autovec}), 32'd0);
        check_val("rd_rdata_hold", 32'(bif.rsp_rdata), 32'h1234);

        // Interrupt acknowledge, VPA held 3 extra cycles
        run_cmd(1'b0, 3'b111, 23'h7FFFF3, 2'b11, 16'h0000, 16'h0019, 2, 3, 50);
        check_val("iack_rdata_cleared", 32'(first_rdata), 32'd0);
        check_val("iack_fc", 32'(cap_fc), 32'd7);
        check_val("iack_autovec", 32'(r_autovec), 32'd1);
        check_val("iack_err", 32'(r_err), 32'd0);
        check_val("iack_rdata", 32'(r_rdata), 32'h0019);

        // BERR and DTACK on the same edge: bus error wins
        run_cmd(1'b0, 3'b010, 23'h000400, 2'b11, 16'h0000, 16'hA5A5, 3, 0, 50);
        check_val("berr_err", 32'(r_err), 32'd1);
        check_val("berr_rdata", 32'(r_rdata), 32'd0);
        check_val("berr_autovec", 32'(r_autovec), 32'd0);

        // Illegal byte enables: immediate error, no strobe
        run_cmd(1'b1, 3'b001, 23'h000010, 2'b00, 16'h1111, 16'h0000, 1, 0, 20);
        check_val("be0_got", 32'(got_rsp), 32'd1);
        check_val("be0_err", 32'(r_err), 32'd1);
        check_val("be0_as_seen", 32'(as_seen), 32'd0);
        check_val("be0_latency", 32'(lat), 32'd1);

`ifdef M68K_BUS_INITIATOR_TIMEOUT_EN
        run_cmd(1'b0, 3'b001, 23'h001000, 2'b11, 16'h0000, 16'h7777, 0, 0, 400);
        check_val("to_got", 32'(got_rsp), 32'd1);
        check_val("to_err", 32'(r_err), 32'd1);
        check_val("to_rdata", 32'(r_rdata), 32'd0);
        check_val("to_strobe_cycles", 32'(strobe_cnt), 32'd255);
        run_cmd(1'b0, 3'b001, 23'h001000, 2'b11, 16'h0000, 16'h7777, 0, 0, 20);
`else
        run_cmd(1'b0, 3'b001, 23'h001000, 2'b11, 16'h0000, 16'h7777, 0, 0, 1000);
        check_val("noresp_got", 32'(got_rsp), 32'd0);
`endif
        // Reset while AS is asserted
        check_val("pre_rst_as_n", 32'(bif.as_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n}), 32'd7);
        check_val("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("postrst_ready", 32'(bif.cmd_ready), 32'd1);

        run_cmd(1'b1, 3'b110, 23'h7FFFFF, 2'b10, 16'h5A5A, 16'h0000, 1, 0, 50);
        check_val("post_got", 32'(got_rsp), 32'd1);
        check_val("post_ds", 32'({cap_uds, cap_lds}), 32'd1);
        check_val("post_addr", 32'(cap_addr), 32'h7FFFFF);
        check_val("post_err", 32'(r_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
